ps2_rx_fifo: RTL and testbench



---
 rtl/ps2_pkg.sv | 20 ++
 rtl/ps2_line_filter.sv | 37 +++
 rtl/ps2_rx_fifo.sv | 169 ++++++++++++++++
 tb/tb_ps2_rx_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared state encoding and parity helper for the PS/2 receiver.
`default_nettype none

package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_t;

  // True when the data byte plus its parity bit carry an odd number of ones.
  function automatic logic odd_parity_ok(input logic [7:0] bits, input logic par);
    return (^bits) ^ par;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser plus deglitch counter for one PS/2 line.
`default_nettype none

module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  logic [1:0] sync;
  logic [7:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 2'b11;
      cnt  <= 8'd0;
      filt <= 1'b1;
    end else begin
      sync <= {sync[0], raw};
      // Any sample that agrees with the current level restarts the run.
      if (sync[1] == filt) begin
        cnt <= 8'd0;
      end else if (cnt == 8'(FILTER_LEN - 1)) begin
        filt <= sync[1];
        cnt  <= 8'd0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/ps2_rx_fifo.sv
// ps2_rx_fifo: PS/2 device-to-host receiver with frame checks and show-ahead byte FIFO.
// Optional host inhibit on ps2_clk_oe when PS2_RX_INHIBIT_EN is defined.
`default_nettype none

module ps2_rx_fifo
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 50000,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic       rd,
  output logic [7:0] data,
  output logic       valid,
  output logic       err_parity,
  output logic       err_frame,
  output logic       overflow,
  output logic       ps2_clk_oe
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);

  logic fclk, fdat, fclk_q, bit_evt, bit_val, clk_edge;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(clk), .reset(reset), .raw(ps2_clk), .filt(fclk)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filt (
    .clk(clk), .reset(reset), .raw(ps2_dat), .filt(fdat)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      fclk_q  <= 1'b1;
      bit_evt <= 1'b0;
      bit_val <= 1'b1;
    end else begin
      fclk_q  <= fclk;
      bit_evt <= fclk_q & ~fclk;
      bit_val <= fdat;
    end
  end

  assign clk_edge = fclk_q ^ fclk;

  ps2_rx_state_t state, state_n;
  logic [2:0]    bit_cnt, bit_cnt_n;
  logic [7:0]    shreg, shreg_n;
  logic          par_ok, par_ok_n;
  logic          push, perr, ferr;
  logic [TW-1:0] tcnt;
  logic          timeout;

  assign timeout = (state != IDLE) && (tcnt == TW'(TIMEOUT_CYC));

  always_ff @(posedge clk) begin
    if (reset || state == IDLE || clk_edge) begin
      tcnt <= '0;
    end else begin
      tcnt <= tcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      bit_cnt <= 3'd0;
      shreg   <= 8'd0;
      par_ok  <= 1'b0;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_cnt_n;
      shreg   <= shreg_n;
      par_ok  <= par_ok_n;
    end
  end

  always_comb begin
    state_n   = state;
    bit_cnt_n = bit_cnt;
    shreg_n   = shreg;
    par_ok_n  = par_ok;
    push      = 1'b0;
    perr      = 1'b0;
    ferr      = 1'b0;
    if (timeout) begin
      state_n = IDLE;
      ferr    = 1'b1;
    end else if (bit_evt) begin
      case (state)
        IDLE: begin
          if (!bit_val) begin
            state_n   = DATA;
            bit_cnt_n = 3'd0;
          end
        end
        DATA: begin
          shreg_n   = {bit_val, shreg[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = PARITY;
        end
        PARITY: begin
          par_ok_n = odd_parity_ok(shreg, bit_val);
          state_n  = STOP;
        end
        STOP: begin
          state_n = IDLE;
          if (!bit_val)     ferr = 1'b1;
          else if (!par_ok) perr = 1'b1;
          else              push = 1'b1;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr;
  logic        empty, full, pop, wr_en;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop   = rd & ~empty;
  // When full, a simultaneous pop frees the very slot being written.
  assign wr_en = push & (~full | pop);

  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr[AW-1:0]] <= shreg;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      err_parity <= 1'b0;
      err_frame  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (pop)   rptr <= rptr + 1'b1;
      err_parity <= perr;
      err_frame  <= ferr;
      overflow   <= push & full & ~pop;
    end
  end

  assign valid = ~empty;
  assign data  = empty ? 8'h00 : mem[rptr[AW-1:0]];

`ifdef PS2_RX_INHIBIT_EN
  logic oe_q;
  always_ff @(posedge clk) begin
    if (reset) oe_q <= 1'b0;
    else       oe_q <= full && (state == IDLE);
  end
  assign ps2_clk_oe = oe_q;
`else
  assign ps2_clk_oe = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_ps2_rx_fifo.sv
// tb_ps2_rx_fifo: directed PS/2 frames with a queue-based scoreboard and monitor.
`default_nettype none

module tb_ps2_rx_fifo;

  localparam int FL    = 8;
  localparam int TO    = 2000;
  localparam int DEPTH = 8;
  localparam int H     = 30;
  localparam int K_PAR = 1;
  localparam int K_FRM = 2;
  localparam int K_OVF = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_dat = 1'b1;
  logic       rd = 1'b0;
  logic [7:0] data;
  logic       valid, err_parity, err_frame, overflow, ps2_clk_oe;

  int checks = 0;
  int errors = 0;
  logic [7:0] byte_q[$];
  int         err_q[$];

  ps2_rx_fifo #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat), .rd(rd),
    .data(data), .valid(valid), .err_parity(err_parity), .err_frame(err_frame),
    .overflow(overflow), .ps2_clk_oe(ps2_clk_oe)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_err(input int kind, input string name);
    if (err_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s: got unexpected pulse expected none", name);
    end else begin
      chk(name, 32'(kind), 32'(err_q.pop_front()));
    end
  endtask

  // Monitor: compares every error pulse and every accepted pop against the queues.
  always @(negedge clk) begin
    if (!reset) begin
      if (err_parity) expect_err(K_PAR, "err_parity");
      if (err_frame)  expect_err(K_FRM, "err_frame");
      if (overflow)   expect_err(K_OVF, "overflow");
      if (rd && valid) begin
        if (byte_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL rd_data: got %0h expected no byte", data);
        end else begin
          chk("rd_data", 32'(data), 32'(byte_q.pop_front()));
        end
      end
`ifndef PS2_RX_INHIBIT_EN
      if (ps2_clk_oe !== 1'b0) begin
        checks++;
        errors++;
        $display("FAIL oe_const: got %0b expected 0", ps2_clk_oe);
      end
`endif
    end
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    ps2_dat = b;
    if (glitch) begin
      wait_cyc(15);
      ps2_clk = 1'b0;
      wait_cyc(3);
      ps2_clk = 1'b1;
      wait_cyc(H - 18);
    end else begin
      wait_cyc(H);
    end
    ps2_clk = 1'b0;
    wait_cyc(H);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit par_flip, input logic stop,
                            input int glitch_bit);
    logic p;
    p = (~^b) ^ par_flip;
    send_bit(1'b0, glitch_bit == 0);
    for (int i = 0; i < 8; i++) send_bit(b[i], glitch_bit == i + 1);
    send_bit(p, 1'b0);
    send_bit(stop, 1'b0);
    ps2_dat = 1'b1;
    wait_cyc(60);
  endtask

  task automatic good_frame(input logic [7:0] b);
    byte_q.push_back(b);
    send_frame(b, 1'b0, 1'b1, -1);
  endtask

  task automatic pop_one();
    int n;
    n = 0;
    while (!valid && n < 2000) begin
      wait_cyc(1);
      n++;
    end
    if (!valid) begin
      checks++;
      errors++;
      $display("FAIL pop_timeout: got valid=0 expected valid=1");
    end else begin
      rd = 1'b1;
      wait_cyc(1);
      rd = 1'b0;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    wait_cyc(5);
    chk("rst_data", 32'(data), 32'h00);
    chk("rst_valid", 32'(valid), 32'h0);
    chk("rst_errs", 32'({err_parity, err_frame, overflow}), 32'h0);
    chk("rst_oe", 32'(ps2_clk_oe), 32'h0);
    reset = 1'b0;
    wait_cyc(20);

    good_frame(8'h1C);
    chk("single_valid", 32'(valid), 32'h1);
    chk("single_data", 32'(data), 32'h1C);
    pop_one();

    good_frame(8'hF0);
    good_frame(8'h1C);
    pop_one();
    pop_one();
    chk("two_empty", 32'(valid), 32'h0);

    err_q.push_back(K_PAR);
    send_frame(8'h1C, 1'b1, 1'b1, -1);
    chk("par_valid", 32'(valid), 32'h0);
    err_q.push_back(K_FRM);
    send_frame(8'h1C, 1'b0, 1'b0, -1);
    chk("stop_valid", 32'(valid), 32'h0);

    err_q.push_back(K_FRM);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    ps2_dat = 1'b1;
    wait_cyc(TO + 100);
    chk("to_valid", 32'(valid), 32'h0);
    good_frame(8'h45);
    pop_one();

    for (int i = 1; i <= 9; i++) begin
      if (i <= DEPTH) good_frame(8'(i));
      else begin
        err_q.push_back(K_OVF);
        send_frame(8'(i), 1'b0, 1'b1, -1);
      end
    end
`ifdef PS2_RX_INHIBIT_EN
    chk("oe_full", 32'(ps2_clk_oe), 32'h1);
`endif
    pop_one();
    wait_cyc(3);
`ifdef PS2_RX_INHIBIT_EN
    chk("oe_release", 32'(ps2_clk_oe), 32'h0);
`endif
    for (int i = 0; i < DEPTH - 1; i++) pop_one();
    chk("ovf_empty", 32'(valid), 32'h0);

    byte_q.push_back(8'h2D);
    send_frame(8'h2D, 1'b0, 1'b1, 4);
    pop_one();

    wait_cyc(50);
    chk("byte_q_drained", 32'(byte_q.size()), 32'h0);
    chk("err_q_drained", 32'(err_q.size()), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
